ybus_reader: RTL and testbench
==============================

# ybus_reader

Consumer-side reader for the wide packed `y` result bus that generated fault-test designs drive. On a capture request it snapshots the full bus and streams it out as fixed-width beats over a valid/ready handshake. While streaming it folds every accepted beat into a 32-bit per-frame MISR signature. It sits between a device under test and the comparison/logging path, so golden and faulty results are read back and compared in exactly the same way.

## Interface
Parameters:
- `Y_W`, 181: width of the captured result bus.
- `CHUNK_W`, 32: beat width. `NBEATS = ceil(Y_W/CHUNK_W)`, which is 6 at the defaults.
- `POLY`, 32'h04C11DB7: MISR feedback polynomial.

Ports:
- `clk`  in  1: sole clock; all state changes on its rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `y_in`  in  Y_W: result bus being read.
- `cap_req`  in  1: capture request, sampled each cycle.
- `cap_busy`  out  1: frame in progress (state SEND).
- `out_data`  out  CHUNK_W: current beat.
- `out_valid`  out  1: beat valid.
- `out_ready`  in  1: sink accepts the beat.
- `out_last`  out  1: current beat is beat NBEATS-1.
- `sig`  out  32: signature of the last completed frame.
- `sig_valid`  out  1: one-cycle pulse when `sig` updates.
- `frame_cnt`  out  16: completed frames, wraps at 16'hFFFF to 0.
- `overrun`  out  1: sticky flag; a capture request was dropped.

## Operation
- Reset forces every register and output to 0: `cap_busy`, `out_data`, `out_valid`, `out_last`, `sig`, `sig_valid`, `frame_cnt`, `overrun`, the shadow register, beat index and accumulator. State returns to IDLE. Reset has immediate effect, including mid-frame; the partial frame is discarded and is neither counted nor signed.
- FSM states are IDLE and SEND.
- IDLE with `cap_req`=1:
  - Latch `y_in` into the shadow register, zero-extended to NBEATS*CHUNK_W bits.
  - Set index=0, clear the accumulator, go to SEND.
- SEND, driven outputs:
  - `out_valid`=1 and `out_data` = shadow[index*CHUNK_W +: CHUNK_W].
  - `out_last` = (index==NBEATS-1).
  - Final beat carries the Y_W mod CHUNK_W valid bits in its LSBs; the upper bits are 0. At defaults that is 21 bits, with bits [31:21]=0.
- Handshake: a beat transfers only when `out_valid`&&`out_ready` on a clock edge.
  - `out_data` is held stable until the beat transfers.
  - `out_ready`=0 stalls the block indefinitely; nothing is lost.
- Each transferred beat updates the accumulator: acc_next = ({acc[30:0],1'b0} ^ (acc[31] ? POLY : 0)) ^ out_data. CHUNK_W is 32 at the defaults.
- Transfer of the last beat:
  - `sig` <= acc_next (the value including the last beat).
  - `sig_valid` pulses, `frame_cnt` increments, state returns to IDLE.
- `cap_req` during SEND, when not on the last-beat transfer cycle: the request is ignored and `overrun` is set to 1. `overrun` clears only on reset.
- Simultaneous `cap_req` and last-beat transfer: the new frame is captured with zero bubble. State stays SEND, the shadow reloads, index=0 and the accumulator clears. `sig`, `sig_valid` and `frame_cnt` still complete the old frame. `overrun` is not set.
- `y_in` is sampled only on the capture edge; later changes do not affect the frame in flight.

## Timing
- Capture edge T, meaning `cap_req`=1 sampled in IDLE: `out_valid`, `cap_busy` and beat 0 are visible from T+1.
- Beats advance one per cycle under continuous `out_ready`=1, so a frame is NBEATS cycles (T+1..T+6 at defaults).
- `sig`, `sig_valid` and `frame_cnt` are registered and visible in the cycle after the last transfer. `sig_valid` is high for exactly 1 cycle.
- After a normal frame end `out_valid`=0 for at least 1 cycle. A zero-bubble recapture is the exception: `out_valid` stays 1.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Reset, then `y_in`=0, one `cap_req` pulse, `out_ready`=1:
  - Six beats of 32'h0, `out_last` on beat 6.
  - `sig`=0, `sig_valid` pulse 1 cycle after beat 6, `frame_cnt`=1.
- `y_in`=181'h1:
  - beat0=32'h00000001, beats1-5=0.
  - `sig` equals the reference-model MISR value of that beat sequence.
- `y_in` all ones, with `out_ready` toggling 1,0,0,1,…:
  - Beats 0-4 = 32'hFFFFFFFF, beat 5 = 32'h001FFFFF.
  - `out_data` is held through stalls and `y_in` changes mid-frame are not reflected.
- `cap_req` on beat 2 of a frame, then `cap_req` on the last-beat transfer edge with a new `y_in`:
  - First request sets `overrun`=1 and the frame is unaffected.
  - Second request starts the next frame with no `out_valid` gap; `frame_cnt` goes 1 then 2.
- `rst` asserted mid-frame at beat 3: all outputs go to 0 immediately, `frame_cnt` stays at its pre-frame value… then 0 on reset. A subsequent capture of `y_in`=0 produces a clean 6-beat frame with `sig`=0.
- Run 65536 frames: `frame_cnt` wraps from 16'hFFFF to 0.

Source files
------------

// File: rtl/ybus_reader.sv
// ybus_reader: snapshots a wide result bus and streams it out as beats.
// Each accepted beat is folded into a 32-bit per-frame MISR signature.
//
// Ports:
//   clk, rst      clock, async active-high reset
//   y_in          result bus, sampled only on the capture edge
//   cap_req       capture request
//   cap_busy      frame in progress
//   out_data      current beat (zero outside a frame)
//   out_valid     beat valid
//   out_ready     sink accepts beat
//   out_last      current beat is the final one
//   sig           signature of the last completed frame
//   sig_valid     one-cycle pulse when sig updates
//   frame_cnt     completed frames, wrapping
//   overrun       sticky: a capture request was dropped
module ybus_reader #(
  parameter int          Y_W     = 181,
  parameter int          CHUNK_W = 32,
  parameter logic [31:0] POLY    = 32'h04C11DB7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [Y_W-1:0]     y_in,
  input  logic               cap_req,
  output logic               cap_busy,
  output logic [CHUNK_W-1:0] out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_last,
  output logic [31:0]        sig,
  output logic               sig_valid,
  output logic [15:0]        frame_cnt,
  output logic               overrun
);

  localparam int NBEATS = (Y_W + CHUNK_W - 1) / CHUNK_W;
  localparam int IW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int SH_W   = NBEATS * CHUNK_W;

  typedef enum logic {IDLE, SEND} state_t;

  state_t state, state_nx;

  logic [NBEATS-1:0][CHUNK_W-1:0] shadow;
  logic [IW-1:0]                  idx;
  logic [31:0]                    acc;
  logic [31:0]                    acc_nx;
  logic                           send;
  logic                           last;
  logic                           xfer;
  logic                           end_xfer;
  logic                           cap_new;
  logic                           drop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    send     = (state == SEND);
    last     = send && (idx == IW'(NBEATS - 1));
    xfer     = send && out_ready;
    end_xfer = xfer && last;
    // A request landing on the final transfer starts the next
    // frame back-to-back; anywhere else in a frame it is dropped.
    cap_new  = cap_req && (!send || end_xfer);
    drop     = cap_req && send && !end_xfer;
    acc_nx   = {acc[30:0], 1'b0}
             ^ (acc[31] ? POLY : 32'h0)
             ^ 32'(out_data);
    state_nx = state;
    unique case (state)
      IDLE: if (cap_req) state_nx = SEND;
      SEND: if (end_xfer && !cap_req) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign cap_busy  = send;
  assign out_valid = send;
  assign out_last  = last;
  assign out_data  = send ? shadow[idx] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow    <= '0;
      idx       <= '0;
      acc       <= '0;
      sig       <= '0;
      sig_valid <= 1'b0;
      frame_cnt <= '0;
      overrun   <= 1'b0;
    end else begin
      sig_valid <= 1'b0;
      if (drop) overrun <= 1'b1;
      if (cap_new) begin
        shadow <= SH_W'(y_in);
        idx    <= '0;
        acc    <= '0;
      end else if (xfer) begin
        idx <= last ? '0 : idx + 1'b1;
        acc <= acc_nx;
      end
      if (end_xfer) begin
        sig       <= acc_nx;
        sig_valid <= 1'b1;
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ybus_reader.sv
// tb_ybus_reader: vector table plus beat/signature scoreboard.
// A second narrow instance exercises the frame counter wrap.
module tb_ybus_reader;

  localparam logic [31:0] POLY = 32'h04C11DB7;

  typedef struct {
    logic [180:0]     y;
    logic [5:0][31:0] b;
    logic [31:0]      s;
    logic             stall;
  } vec_t;

  typedef struct {
    logic [31:0] d;
    logic        last;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [180:0] y_in = '0;
  logic         cap_req = 1'b0;
  logic         out_ready = 1'b1;
  logic         cap_busy;
  logic [31:0]  out_data;
  logic         out_valid;
  logic         out_last;
  logic [31:0]  sig;
  logic         sig_valid;
  logic [15:0]  frame_cnt;
  logic         overrun;

  logic [31:0] w_y = 32'h0;
  logic        w_cap = 1'b0;
  logic        w_ready = 1'b0;
  logic        w_busy;
  logic [31:0] w_data;
  logic        w_valid;
  logic        w_last;
  logic [31:0] w_sig;
  logic        w_sigv;
  logic [15:0] w_cnt;
  logic        w_ovr;

  vec_t  tab [4];
  beat_t exp_q [$];
  logic [31:0] sig_q [$];
  int    nchk = 0;
  int    npass = 0;
  int    exp_cnt = 0;
  logic [3:0] pat = 4'b1001;

  always #5 clk = ~clk;

  ybus_reader dut (
    .clk(clk), .rst(rst), .y_in(y_in), .cap_req(cap_req),
    .cap_busy(cap_busy), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .sig(sig), .sig_valid(sig_valid),
    .frame_cnt(frame_cnt), .overrun(overrun)
  );

  ybus_reader #(.Y_W(32), .CHUNK_W(32)) wdut (
    .clk(clk), .rst(rst), .y_in(w_y), .cap_req(w_cap),
    .cap_busy(w_busy), .out_data(w_data),
    .out_valid(w_valid), .out_ready(w_ready),
    .out_last(w_last), .sig(w_sig), .sig_valid(w_sigv),
    .frame_cnt(w_cnt), .overrun(w_ovr)
  );

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  function automatic logic [31:0] misr(logic [5:0][31:0] b);
    logic [31:0] a = '0;
    for (int i = 0; i < 6; i++)
      a = ({a[30:0], 1'b0} ^ (a[31] ? POLY : 32'h0)) ^ b[i];
    return a;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(int k);
    for (int i = 0; i < 6; i++) begin
      beat_t e;
      e.d = tab[k].b[i];
      e.last = (i == 5);
      exp_q.push_back(e);
    end
    sig_q.push_back(tab[k].s);
  endtask

  task automatic capture(int k);
    y_in = tab[k].y;
    cap_req = 1'b1;
    out_ready = 1'b1;
    push(k);
    step();
    cap_req = 1'b0;
  endtask

  task automatic wait_sig(bit stall);
    bit got = 1'b0;
    for (int c = 0; c < 60 && !got; c++) begin
      if (stall) begin
        out_ready = pat[c % 4];
        y_in = 181'({$urandom, $urandom, $urandom,
                     $urandom, $urandom, $urandom});
      end
      step();
      got = sig_valid;
    end
    out_ready = 1'b1;
    exp_cnt++;
    chk("sig_timeout", 64'(got), 64'd1);
    chk("frame_cnt", 64'(frame_cnt), 64'(exp_cnt));
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_busy"}, 64'(cap_busy), 64'd0);
    chk({tag, "_data"}, 64'(out_data), 64'd0);
    chk({tag, "_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_last"}, 64'(out_last), 64'd0);
    chk({tag, "_sig"}, 64'(sig), 64'd0);
    chk({tag, "_sigv"}, 64'(sig_valid), 64'd0);
    chk({tag, "_cnt"}, 64'(frame_cnt), 64'd0);
    chk({tag, "_ovr"}, 64'(overrun), 64'd0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("sb_beat_empty", 64'(out_data), 64'hDEAD);
        end else begin
          chk("beat_data", 64'(out_data), 64'(exp_q[0].d));
          chk("beat_last", 64'(out_last), 64'(exp_q[0].last));
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      if (sig_valid) begin
        if (sig_q.size() == 0) begin
          chk("sb_sig_empty", 64'(sig), 64'hDEAD);
        end else begin
          chk("sig", 64'(sig), 64'(sig_q[0]));
          void'(sig_q.pop_front());
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tab[0].y = '0;
    tab[0].b = '0;
    tab[0].s = 32'h0;
    tab[0].stall = 1'b0;
    tab[1].y = 181'h1;
    tab[1].b = {32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h1};
    tab[1].s = 32'h00000020;
    tab[1].stall = 1'b0;
    tab[2].y = '1;
    tab[2].b = {32'h001FFFFF, {5{32'hFFFFFFFF}}};
    tab[2].s = misr(tab[2].b);
    tab[2].stall = 1'b1;
    tab[3].y = {21'h1ABCDE, 32'hDEADBEEF, 32'h01234567,
                32'h89ABCDEF, 32'hCAFEBABE, 32'h80000001};
    tab[3].b = {32'h001ABCDE, 32'hDEADBEEF, 32'h01234567,
                32'h89ABCDEF, 32'hCAFEBABE, 32'h80000001};
    tab[3].s = misr(tab[3].b);
    tab[3].stall = 1'b0;

    step();
    step();
    chk_zero("rst");
    rst = 1'b0;
    step();

    for (int k = 0; k < 4; k++) begin
      capture(k);
      chk("busy_t1", 64'(cap_busy), 64'd1);
      wait_sig(tab[k].stall);
      chk("end_valid", 64'(out_valid), 64'd0);
      chk("end_busy", 64'(cap_busy), 64'd0);
      step();
      chk("sigv_pulse", 64'(sig_valid), 64'd0);
    end

    // back-to-back recapture on the final beat
    capture(3);
    for (int i = 0; i < 5; i++) step();
    chk("zb_last", 64'(out_last), 64'd1);
    y_in = tab[1].y;
    cap_req = 1'b1;
    push(1);
    step();
    cap_req = 1'b0;
    exp_cnt++;
    chk("zb_sigv", 64'(sig_valid), 64'd1);
    chk("zb_valid", 64'(out_valid), 64'd1);
    chk("zb_cnt", 64'(frame_cnt), 64'(exp_cnt));
    chk("zb_ovr", 64'(overrun), 64'd0);
    wait_sig(1'b0);

    // request mid-frame is dropped and flagged
    step();
    capture(2);
    step();
    step();
    y_in = tab[0].y;
    cap_req = 1'b1;
    step();
    cap_req = 1'b0;
    chk("ovr_set", 64'(overrun), 64'd1);
    wait_sig(1'b0);
    step();
    chk("ovr_idle", 64'(out_valid), 64'd0);

    // reset mid-frame at beat 3
    capture(3);
    step();
    step();
    step();
    chk("mid_cnt", 64'(frame_cnt), 64'(exp_cnt));
    rst = 1'b1;
    exp_q.delete();
    sig_q.delete();
    exp_cnt = 0;
    #1;
    chk_zero("midrst");
    step();
    rst = 1'b0;
    step();
    capture(0);
    wait_sig(1'b0);
    step();
    chk("q_beats", 64'(exp_q.size()), 64'd0);
    chk("q_sigs", 64'(sig_q.size()), 64'd0);

    // counter wrap on a one-beat instance, one frame per cycle
    w_cap = 1'b1;
    w_ready = 1'b1;
    step();
    for (int n = 1; n <= 65536; n++) begin
      w_y = 32'(n);
      step();
      if (n == 65535) chk("wrap_ffff", 64'(w_cnt), 64'hFFFF);
      if (n == 65536) chk("wrap_zero", 64'(w_cnt), 64'h0);
    end
    chk("wrap_valid", 64'(w_valid), 64'd1);
    chk("wrap_ovr", 64'(w_ovr), 64'd0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
